// File: rtl/imem_debug_arbiter.sv
// Arbitrates the single instruction-memory port between the fetch stage and
// the debug/loader port, and sequences fetch halt/resume so program images
// can be written into imem while the core is stopped.
module imem_debug_arbiter #(
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned MAX_DBG_BURST = 4,
  parameter int unsigned HALT_ON_RESET = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  input  logic        dbg_halt,
  output logic        halted,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned BURST_W = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_halted;
  logic [BURST_W-1:0]   r_burst_cnt;

  // In-flight access bookkeeping, captured at grant
  logic                 r_busy;
  logic                 r_id_dbg;
  logic                 r_bad;
  logic                 r_we;

  logic                 r_mem_re;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;

  // Response flags; read data itself is steered straight from imem
  logic                 r_fetch_valid;
  logic                 r_fetch_mem;
  logic                 r_fetch_nop;
  logic                 r_dbg_ack;
  logic                 r_dbg_err;
  logic                 r_dbg_mem;

  logic                 w_idle;
  logic                 w_fetch_ok;
  logic                 w_burst_full;
  logic                 w_grant_dbg;
  logic                 w_grant_fetch;
  logic                 w_dbg_reject;
  logic                 w_fetch_bad;

  // Misaligned or beyond the last word
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  assign w_fetch_ok    = (r_state == ST_RUN);
  assign w_idle        = !r_busy && (r_state != ST_DRAIN);
  assign w_burst_full  = (r_burst_cnt >= BURST_W'(MAX_DBG_BURST));
  assign w_grant_dbg   = w_idle && dbg_req && !(w_fetch_ok && fetch_req && w_burst_full);
  assign w_grant_fetch = w_idle && w_fetch_ok && fetch_req && !w_grant_dbg;
  assign w_dbg_reject  = addr_bad(dbg_addr) || (dbg_we && (r_state != ST_HALTED));
  assign w_fetch_bad   = addr_bad(fetch_addr);

  // Halt sequencing: RUN -> DRAIN/HALTED -> RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= (HALT_ON_RESET != 0) ? ST_HALTED : ST_RUN;
      r_halted <= (HALT_ON_RESET != 0);
    end else begin
      r_halted <= (r_state == ST_HALTED);
      case (r_state)
        ST_RUN: begin
          if (dbg_halt) begin
            r_state <= ((r_busy && !r_id_dbg) || w_grant_fetch) ? ST_DRAIN : ST_HALTED;
          end
        end
        ST_DRAIN:  r_state <= dbg_halt ? ST_HALTED : ST_RUN;
        ST_HALTED: if (!dbg_halt) r_state <= ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  // Consecutive debug grants while fetch is waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_burst_cnt <= '0;
    end else if (!fetch_req || w_grant_fetch || (r_state != ST_RUN)) begin
      r_burst_cnt <= '0;
    end else if (w_grant_dbg) begin
      r_burst_cnt <= r_burst_cnt + BURST_W'(1);
    end
  end

  // Grant and memory-cycle issue; rejected accesses issue no memory cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_id_dbg    <= 1'b0;
      r_bad       <= 1'b0;
      r_we        <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_busy   <= w_grant_dbg || w_grant_fetch;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      if (w_grant_dbg) begin
        r_id_dbg    <= 1'b1;
        r_bad       <= w_dbg_reject;
        r_we        <= dbg_we;
        r_mem_re    <= !w_dbg_reject && !dbg_we;
        r_mem_we    <= !w_dbg_reject && dbg_we;
        r_mem_addr  <= dbg_addr;
        r_mem_wdata <= dbg_wdata;
      end else if (w_grant_fetch) begin
        r_id_dbg    <= 1'b0;
        r_bad       <= w_fetch_bad;
        r_we        <= 1'b0;
        r_mem_re    <= !w_fetch_bad;
        r_mem_addr  <= fetch_addr;
      end
    end
  end

  // Completion pulses one cycle after grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_mem   <= 1'b0;
      r_fetch_nop   <= 1'b0;
      r_dbg_ack     <= 1'b0;
      r_dbg_err     <= 1'b0;
      r_dbg_mem     <= 1'b0;
    end else begin
      r_fetch_valid <= r_busy && !r_id_dbg;
      r_fetch_mem   <= r_busy && !r_id_dbg && !r_bad;
      r_fetch_nop   <= r_busy && !r_id_dbg && r_bad;
      r_dbg_ack     <= r_busy && r_id_dbg;
      r_dbg_err     <= r_busy && r_id_dbg && r_bad;
      r_dbg_mem     <= r_busy && r_id_dbg && !r_bad && !r_we;
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = r_fetch_mem ? mem_rdata : (r_fetch_nop ? NOP_INSN : 32'h0);
  assign dbg_ack     = r_dbg_ack;
  assign dbg_err     = r_dbg_err;
  assign dbg_rdata   = r_dbg_mem ? mem_rdata : 32'h0;
  assign halted      = r_halted;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;

endmodule
